// File: rtl/placement_controller_if.sv
// rtl/placement_controller_if.sv - move request / tray / game-state bundle for placement_controller
//
// Purpose: groups the move request, tray shapes, refill handshake and
// game-state outputs of placement_controller into one bundle.
// Signals:
//   start_new, place_req, place_sel[1:0], place_x[2:0], place_y[2:0],
//   block1..block3[63:0], refill_done            : driven by master
//   refill_req, busy, place_ack, place_ok, used[2:0],
//   game_grid[63:0], score[7:0], game_over       : driven by slave (controller)
interface placement_controller_if;
  logic        start_new;
  logic        place_req;
  logic [1:0]  place_sel;
  logic [2:0]  place_x;
  logic [2:0]  place_y;
  logic [63:0] block1;
  logic [63:0] block2;
  logic [63:0] block3;
  logic        refill_done;
  logic        refill_req;
  logic        busy;
  logic        place_ack;
  logic        place_ok;
  logic [2:0]  used;
  logic [63:0] game_grid;
  logic [7:0]  score;
  logic        game_over;

  modport master (
    output start_new, place_req, place_sel, place_x, place_y,
           block1, block2, block3, refill_done,
    input  refill_req, busy, place_ack, place_ok, used, game_grid, score, game_over
  );

  modport slave (
    input  start_new, place_req, place_sel, place_x, place_y,
           block1, block2, block3, refill_done,
    output refill_req, busy, place_ack, place_ok, used, game_grid, score, game_over
  );
endinterface

// File: rtl/placement_controller.sv
// rtl/placement_controller.sv - move sequencer for the 8x8 block game
//
// Purpose: accepts a place command, checks fit, merges the shape into the
// grid, clears full rows/columns, scores, refills the tray and re-evaluates
// game_over by scanning every (slot, position) pair.
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset, clears all state
//   bus    - placement_controller_if.slave (request, tray, refill, game state)
module placement_controller #(
  parameter int CELL_POINTS = 1,
  parameter int LINE_POINTS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  placement_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REJECT, S_PLACE, S_CLEAR, S_REFILL, S_SCAN, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] grid_q, grid_d;
  logic [7:0]  score_q, score_d;
  logic [2:0]  used_q, used_d;
  logic        over_q, over_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  x_q, x_d, y_q, y_d;
  logic [63:0] shape_q, shape_d;
  logic        pend_q, pend_d;   // a request is in flight and owes an ack
  logic        ok_q, ok_d;       // the in-flight request was placed
  logic [1:0]  slot_q, slot_d;   // scan slot, 0 = no candidate left
  logic [5:0]  pos_q, pos_d;     // scan position, {y, x}

  // Zero masks never fit so empty slots can neither be placed nor found by scan.
  function automatic logic fits(input logic [63:0] mask, input logic [2:0] x,
                                input logic [2:0] y, input logic [63:0] grid);
    logic        ovf;
    logic [63:0] sh;
    ovf = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (mask[r*8+c] && ((c + int'(x) > 7) || (r + int'(y) > 7))) ovf = 1'b1;
    sh = mask << {y, x};
    return (mask != '0) && !ovf && ((sh & grid) == '0);
  endfunction

  function automatic logic [6:0] popcount(input logic [63:0] m);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + 7'(m[i]);
    return n;
  endfunction

  // Score sum is formed in 10 bits and clamped so it never wraps.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [9:0] b);
    logic [9:0] s;
    s = {2'b00, a} + b;
    return (s > 10'd255) ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [1:0] first_from(input logic [2:0] e);
    logic [1:0] s;
    s = 2'd0;
    if (e[2]) s = 2'd3;
    if (e[1]) s = 2'd2;
    if (e[0]) s = 2'd1;
    return s;
  endfunction

  logic [63:0] req_shape, scan_shape, clr_mask;
  logic [2:0]  nonzero, elig, after_mask;
  logic        sel_used;
  logic [7:0]  row_full, col_full;
  logic [4:0]  n_lines;

  always_comb begin
    req_shape  = '0;
    scan_shape = '0;
    sel_used   = 1'b0;
    after_mask = 3'b000;
    case (bus.place_sel)
      2'd1: begin req_shape = bus.block1; sel_used = used_q[0]; end
      2'd2: begin req_shape = bus.block2; sel_used = used_q[1]; end
      2'd3: begin req_shape = bus.block3; sel_used = used_q[2]; end
      default: ;
    endcase
    case (slot_q)
      2'd1: begin scan_shape = bus.block1; after_mask = 3'b110; end
      2'd2: begin scan_shape = bus.block2; after_mask = 3'b100; end
      2'd3: scan_shape = bus.block3;
      default: ;
    endcase
    nonzero = {|bus.block3, |bus.block2, |bus.block1};
    elig    = nonzero & ~used_q;
  end

  // Full-line detection on the post-place grid; a cell in both a full row and
  // a full column is simply cleared once by the OR.
  always_comb begin
    logic acc;
    row_full = '0;
    col_full = '0;
    clr_mask = '0;
    n_lines  = '0;
    for (int r = 0; r < 8; r++) row_full[r] = &grid_q[r*8 +: 8];
    for (int c = 0; c < 8; c++) begin
      acc = 1'b1;
      for (int r = 0; r < 8; r++) acc = acc & grid_q[r*8+c];
      col_full[c] = acc;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) clr_mask[r*8+c] = row_full[r] | col_full[c];
    for (int i = 0; i < 8; i++) n_lines = n_lines + 5'(row_full[i]) + 5'(col_full[i]);
  end

  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    score_d = score_q;
    used_d  = used_q;
    over_d  = over_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    shape_d = shape_q;
    pend_d  = pend_q;
    ok_d    = ok_q;
    slot_d  = slot_q;
    pos_d   = pos_q;
    bus.place_ack  = 1'b0;
    bus.place_ok   = 1'b0;
    bus.refill_req = (state_q == S_REFILL);
    if (bus.start_new) begin
      // A request in flight still gets its ack (with ok=0) at DONE.
      grid_d  = '0;
      score_d = '0;
      over_d  = 1'b0;
      used_d  = '0;
      ok_d    = 1'b0;
      state_d = S_REFILL;
    end else begin
      case (state_q)
        S_IDLE: if (bus.place_req) begin
          sel_d   = bus.place_sel;
          x_d     = bus.place_x;
          y_d     = bus.place_y;
          shape_d = req_shape;
          pend_d  = 1'b1;
          ok_d    = 1'b0;
          state_d = (bus.place_sel == 2'd0 || sel_used || over_q) ? S_REJECT : S_CHECK;
        end
        S_CHECK: begin
          ok_d    = fits(shape_q, x_q, y_q, grid_q);
          state_d = ok_d ? S_PLACE : S_REJECT;
        end
        S_REJECT: begin
          bus.place_ack = 1'b1;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_PLACE: begin
          grid_d  = grid_q | (shape_q << {y_q, x_q});
          used_d  = used_q | (3'b001 << (sel_q - 2'd1));
          score_d = sat_add(score_q, 10'(CELL_POINTS) * {3'b000, popcount(shape_q)});
          state_d = S_CLEAR;
        end
        S_CLEAR: begin
          grid_d  = grid_q & ~clr_mask;
          score_d = sat_add(score_q, 10'(LINE_POINTS) * {5'b00000, n_lines});
          slot_d  = first_from(elig);
          pos_d   = '0;
          state_d = (used_q == 3'b111) ? S_REFILL : S_SCAN;
        end
        S_REFILL: if (bus.refill_done) begin
          used_d  = '0;
          slot_d  = first_from(nonzero);
          pos_d   = '0;
          state_d = S_SCAN;
        end
        S_SCAN: begin
          if (slot_q == 2'd0) begin
            over_d  = 1'b1;
            state_d = S_DONE;
          end else if (fits(scan_shape, pos_q[2:0], pos_q[5:3], grid_q)) begin
            state_d = S_DONE;
          end else if (pos_q == 6'd63) begin
            pos_d  = '0;
            slot_d = first_from(elig & after_mask);
            if (first_from(elig & after_mask) == 2'd0) begin
              over_d  = 1'b1;
              state_d = S_DONE;
            end
          end else begin
            pos_d = pos_q + 6'd1;
          end
        end
        S_DONE: begin
          bus.place_ack = pend_q;
          bus.place_ok  = pend_q & ok_q;
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      grid_q  <= '0;
      score_q <= '0;
      used_q  <= '0;
      over_q  <= 1'b0;
      sel_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      shape_q <= '0;
      pend_q  <= 1'b0;
      ok_q    <= 1'b0;
      slot_q  <= '0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      grid_q  <= grid_d;
      score_q <= score_d;
      used_q  <= used_d;
      over_q  <= over_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      shape_q <= shape_d;
      pend_q  <= pend_d;
      ok_q    <= ok_d;
      slot_q  <= slot_d;
      pos_q   <= pos_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.used      = used_q;
  assign bus.game_grid = grid_q;
  assign bus.score     = score_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_placement_controller.sv
// tb/tb_placement_controller.sv - self-checking bench for placement_controller
module tb_placement_controller;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  placement_controller_if bus();
  placement_controller #(.CELL_POINTS(1), .LINE_POINTS(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Game model: 8x8 occupancy, score, consumed slots, tray contents.
  logic [63:0] m_grid;
  int          m_score;
  logic [2:0]  m_used;
  bit          m_over;
  logic [63:0] m_blk [1:3];
  bit          chk_en = 0;
  bit          ack_exp = 0;
  bit          exp_ok = 0;
  int          last_n, last_nr;

  localparam logic [63:0] B1X1 = 64'h1;
  localparam logic [63:0] B1X6 = 64'h3F;
  localparam logic [63:0] B2X2 = 64'h303;
  localparam logic [63:0] BTWO = 64'h00000000007F007F;  // 1x7 on rows 0 and 2

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit m_fits(input logic [63:0] m, input int x, input int y,
                                input logic [63:0] g);
    bit ok;
    ok = (m != 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (m[r*8+c]) begin
          if (r + y > 7 || c + x > 7) ok = 0;
          else if (g[(r+y)*8 + c + x]) ok = 0;
        end
    return ok;
  endfunction

  task automatic m_scan(output bit found, output int tries);
    found = 0;
    tries = 0;
    for (int s = 1; s <= 3; s++)
      if (!found && !m_used[s-1] && m_blk[s] != 0)
        for (int p = 0; p < 64 && !found; p++) begin
          tries++;
          if (m_fits(m_blk[s], p % 8, p / 8, m_grid)) found = 1;
        end
  endtask

  task automatic m_place(input int sel, input int x, input int y);
    logic [63:0] m;
    int cells, lines;
    bit rf [8];
    bit cf [8];
    m = m_blk[sel];
    cells = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (m[r*8+c]) begin
          m_grid[(r+y)*8 + c + x] = 1'b1;
          cells++;
        end
    m_used[sel-1] = 1'b1;
    m_score = (m_score + cells > 255) ? 255 : m_score + cells;
    lines = 0;
    for (int r = 0; r < 8; r++) begin
      rf[r] = 1;
      for (int c = 0; c < 8; c++) if (!m_grid[r*8+c]) rf[r] = 0;
      if (rf[r]) lines++;
    end
    for (int c = 0; c < 8; c++) begin
      cf[c] = 1;
      for (int r = 0; r < 8; r++) if (!m_grid[r*8+c]) cf[c] = 0;
      if (cf[c]) lines++;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (rf[r] || cf[c]) m_grid[r*8+c] = 1'b0;
    m_score = (m_score + 8 * lines > 255) ? 255 : m_score + 8 * lines;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (!bus.busy) begin
        check("idle_grid", bus.game_grid, m_grid);
        check("idle_score", bus.score, m_score[7:0]);
        check("idle_used", bus.used, m_used);
        check("idle_game_over", bus.game_over, m_over);
        check("idle_refill_req", bus.refill_req, 1'b0);
      end
      if (bus.place_ack) begin
        check("ack_expected", ack_exp, 1'b1);
        check("place_ok", bus.place_ok, exp_ok);
      end
    end
  end

  task automatic load_tray(input logic [63:0] b1, input logic [63:0] b2, input logic [63:0] b3);
    bus.block1 = b1;
    bus.block2 = b2;
    bus.block3 = b3;
    m_blk[1] = b1;
    m_blk[2] = b2;
    m_blk[3] = b3;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (bus.busy && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, bus.busy, 1'b0);
  endtask

  task automatic do_start(input logic [63:0] b1, input logic [63:0] b2,
                          input logic [63:0] b3, input int delay);
    int n_req, tries;
    bit found;
    bus.start_new = 1'b1;
    @(posedge clk); #1;
    bus.start_new = 1'b0;
    m_grid = '0; m_score = 0; m_over = 0; m_used = '0;
    n_req = 0;
    for (int i = 0; i < delay; i++) begin
      if (bus.refill_req) n_req++;
      if (i == delay - 1) begin
        load_tray(b1, b2, b3);
        bus.refill_done = 1'b1;
      end
      @(posedge clk); #1;
      bus.refill_done = 1'b0;
    end
    check("refill_req_cycles", n_req, delay);
    check("refill_req_dropped", bus.refill_req, 1'b0);
    m_scan(found, tries);
    if (!found) m_over = 1;
    wait_idle("start_new_timeout");
  endtask

  task automatic do_move(input int sel, input int x, input int y, input logic [63:0] n1,
                         input logic [63:0] n2, input logic [63:0] n3, input bit poke);
    int n, n_r, tries;
    bit accepted, refill, found, got_ack;
    bus.place_sel = 2'(sel);
    bus.place_x = 3'(x);
    bus.place_y = 3'(y);
    bus.place_req = 1'b1;
    ack_exp = 1;
    @(posedge clk); #1;
    bus.place_req = 1'b0;
    n = 1;
    accepted = (sel != 0) && !m_over && m_blk[sel] != 0 && !m_used[sel-1]
               && m_fits(m_blk[sel], x, y, m_grid);
    exp_ok = accepted;
    refill = 0;
    tries = 0;
    if (accepted) begin
      m_place(sel, x, y);
      refill = (m_used == 3'b111);
      if (!refill) begin
        m_scan(found, tries);
        if (!found) m_over = 1;
      end
    end
    n_r = -1;
    got_ack = 0;
    while (n < 600) begin
      if (bus.place_ack) begin
        got_ack = 1;
        break;
      end
      if (bus.refill_req && n_r < 0) begin
        load_tray(n1, n2, n3);
        bus.refill_done = 1'b1;
        n_r = n;
        m_used = '0;
        m_scan(found, tries);
        if (!found) m_over = 1;
      end
      if (poke && n_r >= 0 && n == n_r + 12) bus.place_req = 1'b1;
      @(posedge clk); #1;
      n++;
      bus.refill_done = 1'b0;
      bus.place_req = 1'b0;
    end
    check("ack_seen", got_ack, 1'b1);
    if (accepted) check("ack_latency", n, (n_r < 0) ? 4 + tries : n_r + 1 + tries);
    last_n = n;
    last_nr = n_r;
    @(posedge clk); #1;
    ack_exp = 0;
    wait_idle("move_timeout");
  endtask

  initial begin
    reset = 1'b1;
    bus.start_new = 1'b0;
    bus.place_req = 1'b0;
    bus.place_sel = '0;
    bus.place_x = '0;
    bus.place_y = '0;
    bus.refill_done = 1'b0;
    load_tray('0, '0, '0);
    m_grid = '0; m_score = 0; m_used = '0; m_over = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_grid", bus.game_grid, 64'h0);
    check("rst_score", bus.score, 8'h0);
    check("rst_used", bus.used, 3'b000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_ack", bus.place_ack, 1'b0);
    check("rst_refill_req", bus.refill_req, 1'b0);
    check("rst_game_over", bus.game_over, 1'b0);
    chk_en = 1;

    do_start(B1X1, B1X6, B1X1, 3);
    check("new_grid", bus.game_grid, 64'h0);
    check("new_score", bus.score, 8'd0);

    do_move(1, 0, 0, '0, '0, '0, 0);
    check("p1_grid", bus.game_grid, 64'h1);
    check("p1_score", bus.score, 8'd1);
    check("p1_used", bus.used, 3'b001);

    do_move(1, 0, 0, '0, '0, '0, 0);
    check("reuse_grid", bus.game_grid, 64'h1);
    check("reuse_score", bus.score, 8'd1);

    do_move(2, 1, 0, '0, '0, '0, 0);
    check("row7_grid", bus.game_grid, 64'h7F);
    do_move(3, 7, 0, B2X2, B2X2, '0, 0);
    check("clear_grid", bus.game_grid, 64'h0);
    check("clear_score", bus.score, 8'd16);
    check("refill_used", bus.used, 3'b000);

    do_move(1, 7, 0, '0, '0, '0, 0);
    do_move(0, 0, 0, '0, '0, '0, 0);
    do_move(3, 0, 0, '0, '0, '0, 0);
    check("rejects_score", bus.score, 8'd16);

    do_move(1, 4, 4, '0, '0, '0, 0);
    check("first_hit_latency", last_n, 5);
    check("p2x2_grid", bus.game_grid, 64'h0000303000000000);
    check("p2x2_score", bus.score, 8'd20);

    do_start(BTWO, BTWO, B1X1, 1);
    do_move(1, 0, 1, '0, '0, '0, 0);
    do_move(2, 0, 5, '0, '0, '0, 0);
    do_move(3, 7, 0, B2X2, B2X2, B2X2, 1);
    check("over_flag", bus.game_over, 1'b1);
    check("over_scan_len", last_n - last_nr - 1, 192);
    check("over_score", bus.score, 8'd29);

    do_move(1, 0, 0, '0, '0, '0, 0);
    check("over_sticky", bus.game_over, 1'b1);

    do_start(B1X1, B1X1, B1X1, 2);
    check("restart_over", bus.game_over, 1'b0);
    check("restart_score", bus.score, 8'd0);

    @(posedge clk); #1;
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
